// File: rtl/alu_pkg.sv
// Shared ALU operation-select and opcode constants, used by the ALU,
// the main controller and the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LOADI = 4'b0001;
  localparam logic [3:0] OP_SLTI  = 4'b0010;
  localparam logic [3:0] OP_SLTIU = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_ANDI  = 4'b1010;
  localparam logic [3:0] OP_ORI   = 4'b1011;
  localparam logic [3:0] OP_XORI  = 4'b1100;
  localparam logic [3:0] OP_NORI  = 4'b1101;
  localparam logic [3:0] OP_SRLI  = 4'b1111;

  localparam logic [3:0] FN_NOP = 4'b0000;
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_ADD = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b0011;
  localparam logic [3:0] FN_OR  = 4'b0100;
  localparam logic [3:0] FN_SRL = 4'b1000;
  localparam logic [3:0] FN_SLL = 4'b1001;
  localparam logic [3:0] FN_SLA = 4'b1010;

endpackage

// File: rtl/alu_control.sv
// Translates opcode/function fields into the registered ALU operation select.
// One cycle of latency; unused codes decode to ALU_NOP.
module alu_control
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic [3:0] func,
  output logic [3:0] ALUop
);

  logic [3:0] w_decode;
  logic [3:0] r_aluOp;

  // func only matters for R-type; every other opcode ignores it.
  always_comb begin
    w_decode = ALU_NOP;
    if (op == OP_RTYPE) begin
      case (func)
        FN_AND:  w_decode = ALU_AND;
        FN_ADD:  w_decode = ALU_ADD;
        FN_SUB:  w_decode = ALU_SUB;
        FN_OR:   w_decode = ALU_OR;
        FN_SRL:  w_decode = ALU_SRL;
        FN_SLL:  w_decode = ALU_SLL;
        FN_SLA:  w_decode = ALU_SLL;
        default: w_decode = ALU_NOP;
      endcase
    end else begin
      case (op)
        OP_SLTI:  w_decode = ALU_SLT;
        OP_SLTIU: w_decode = ALU_SLT;
        OP_ADDI:  w_decode = ALU_ADD;
        OP_ANDI:  w_decode = ALU_AND;
        OP_ORI:   w_decode = ALU_OR;
        OP_XORI:  w_decode = ALU_XOR;
        OP_NORI:  w_decode = ALU_NOR;
        OP_SRLI:  w_decode = ALU_SRL;
        default:  w_decode = ALU_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_aluOp <= ALU_NOP;
    else       r_aluOp <= w_decode;
  end

  assign ALUop = r_aluOp;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed sweeps plus randomized
// traffic compared against a table-driven reference model.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op = 4'b0000;
  logic [3:0] func = 4'b0000;
  logic [3:0] ALUop;

  int total = 0;
  int bad = 0;
  logic [3:0] expOp = 4'b0000;
  bit haveExp = 1'b0;

  // Reference decode tables: R-type indexed by func, others indexed by op.
  logic [3:0] rTab [16] = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0,
                            4'hF, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] iTab [16] = '{4'h0, 4'h0, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h0, 4'hF};

  always #5 clk = ~clk;

  alu_control dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .func  (func),
    .ALUop (ALUop)
  );

  function automatic logic [3:0] refDecode(input logic [3:0] o, input logic [3:0] f);
    return (o == 4'b0000) ? rTab[f] : iTab[o];
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] o, input logic [3:0] f,
                               input string tag);
    @(negedge clk);
    if (haveExp) checkOutput({tag, "_hold"}, ALUop, expOp);
    reset = rst;
    op    = o;
    func  = f;
    expOp = rst ? 4'b0000 : refDecode(o, f);
    @(posedge clk);
    #1;
    checkOutput(tag, ALUop, expOp);
    haveExp = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b1, 4'hF, 4'h0, "reset0");
    applyStimulus(1'b1, 4'hF, 4'h0, "reset1");
    applyStimulus(1'b0, 4'hF, 4'h0, "reset_release");

    for (int f = 0; f < 16; f++)
      applyStimulus(1'b0, 4'h1, 4'(f), $sformatf("func_ignored_%0d", f));

    for (int o = 1; o < 16; o++)
      applyStimulus(1'b0, 4'(o), 4'hF, $sformatf("op_sweep_%0d", o));

    for (int f = 0; f < 16; f++)
      applyStimulus(1'b0, 4'h0, 4'(f), $sformatf("rtype_%0d", f));

    // Input change between edges must not reach the output until the next edge.
    applyStimulus(1'b0, 4'h9, 4'h0, "lat_first");
    @(negedge clk);
    op = 4'hD;
    #2;
    checkOutput("lat_mid", ALUop, 4'b0001);
    @(posedge clk);
    #1;
    checkOutput("lat_next", ALUop, 4'b0110);
    expOp = 4'b0110;

    // Glitch on op well before the edge, restored before sampling.
    @(negedge clk);
    op = 4'h0; func = 4'h8;
    #1;
    op = 4'hA;
    @(posedge clk);
    #1;
    checkOutput("glitch", ALUop, 4'b0011);
    expOp = 4'b0011;

    for (int f = 0; f < 8; f++)
      applyStimulus((f == 4), 4'h0, 4'(f + 8), $sformatf("mid_reset_%0d", f));

    for (int n = 0; n < 400; n++) begin
      logic       rst;
      logic [3:0] o;
      logic [3:0] f;
      rst = ($urandom_range(0, 15) == 0);
      o   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      f   = 4'($urandom_range(0, 15));
      applyStimulus(rst, o, f, $sformatf("rand_%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
